// File: rtl/tamagotchi_button_conditioner.sv
// Button front end for the tamagotchi FSM: synchronises and debounces six raw buttons,
// emits press pulses for the need buttons, and levels plus seconds-held counters for reset/test.
module tamagotchi_button_conditioner #(
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_SECONDS    = 5,
    parameter int RAW_ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] raw_btn,
    output logic       btn_salud,
    output logic       btn_energia,
    output logic       btn_hambre,
    output logic       btn_diversion,
    output logic       btn_reset,
    output logic       btn_test,
    output logic [2:0] count_reset,
    output logic [2:0] count_test
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
    localparam logic [2:0]    HOLD_MAX = 3'(HOLD_SECONDS);

    logic [5:0]    w_pressed;
    logic [5:0]    r_sync1;
    logic [5:0]    r_sync2;
    logic [5:0]    r_deb;
    logic [DW-1:0] r_deb_cnt [6];
    logic [3:0]    r_deb_q;
    logic [3:0]    r_pulse;
    logic [1:0]    r_level;
    logic [PW-1:0] r_presc [2];
    logic [2:0]    r_hold  [2];

    // Internally 1 always means pressed, so reset values double as the released state.
    assign w_pressed = (RAW_ACTIVE_LOW != 0) ? ~raw_btn : raw_btn;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_pressed;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_deb <= '0;
            for (int i = 0; i < 6; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_deb[i]     <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_deb_q <= '0;
            r_pulse <= '0;
            r_level <= '0;
        end else begin
            r_deb_q <= r_deb[3:0];
            r_pulse <= r_deb[3:0] & ~r_deb_q;
            r_level <= r_deb[5:4];
        end
    end

    // Counting is gated by the registered level so the first second ends exactly
    // CLK_HZ cycles after btn_reset/btn_test rises, while clearing follows deb so the
    // count drops on the same cycle as the level.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < 2; j++) begin
                r_presc[j] <= '0;
                r_hold[j]  <= '0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (!r_deb[4+j]) begin
                    r_presc[j] <= '0;
                    r_hold[j]  <= '0;
                end else if (r_level[j]) begin
                    if (r_presc[j] == PRE_LAST) begin
                        r_presc[j] <= '0;
                        if (r_hold[j] != HOLD_MAX) begin
                            r_hold[j] <= r_hold[j] + 3'd1;
                        end
                    end else begin
                        r_presc[j] <= r_presc[j] + PW'(1);
                    end
                end
            end
        end
    end

    assign btn_salud     = r_pulse[0];
    assign btn_energia   = r_pulse[1];
    assign btn_hambre    = r_pulse[2];
    assign btn_diversion = r_pulse[3];
    assign btn_reset     = r_level[0];
    assign btn_test      = r_level[1];
    assign count_reset   = r_hold[0];
    assign count_test    = r_hold[1];

endmodule

// File: tb/tb_tamagotchi_button_conditioner.sv
// Directed bench for tamagotchi_button_conditioner at CLK_HZ=10, DEBOUNCE_CYCLES=4,
// HOLD_SECONDS=5, active-high raw pins; a clean press surfaces 7 cycles after the raw edge.
module tb_tamagotchi_button_conditioner;

    logic       clk;
    logic       reset;
    logic [5:0] raw_btn;
    logic       btn_salud;
    logic       btn_energia;
    logic       btn_hambre;
    logic       btn_diversion;
    logic       btn_reset;
    logic       btn_test;
    logic [2:0] count_reset;
    logic [2:0] count_test;

    int n_vec;
    int n_err;

    tamagotchi_button_conditioner #(
        .CLK_HZ         (10),
        .DEBOUNCE_CYCLES(4),
        .HOLD_SECONDS   (5),
        .RAW_ACTIVE_LOW (0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_btn      (raw_btn),
        .btn_salud    (btn_salud),
        .btn_energia  (btn_energia),
        .btn_hambre   (btn_hambre),
        .btn_diversion(btn_diversion),
        .btn_reset    (btn_reset),
        .btn_test     (btn_test),
        .count_reset  (count_reset),
        .count_test   (count_test)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pulses();
        return {btn_diversion, btn_hambre, btn_energia, btn_salud};
    endfunction

    function automatic int hold_exp(input int cyc_since_level);
        int s;
        s = cyc_since_level / 10;
        return (s > 5) ? 5 : s;
    endfunction

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b1;
        raw_btn = 6'b0;
        tick();
        tick();
        chk("rst_pulses", 32'(pulses()), 32'(0));
        chk("rst_levels", 32'({btn_test, btn_reset}), 32'(0));
        chk("rst_count_reset", 32'(count_reset), 32'(0));
        chk("rst_count_test", 32'(count_test), 32'(0));
        reset = 1'b0;
        tick();

        // clean press of salud
        raw_btn = 6'b000001;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("clean_press", 32'(pulses()), (i == 7) ? 32'h1 : 32'h0);
        end
        raw_btn = 6'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("clean_release", 32'(pulses()), 32'h0);
        end

        // hambre bouncing in 3-cycle runs, then stable
        for (int i = 0; i < 12; i++) begin
            raw_btn = (((i / 3) % 2) == 0) ? 6'b000100 : 6'b000000;
            tick();
            chk("bounce", 32'(pulses()), 32'h0);
        end
        raw_btn = 6'b000100;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("bounce_stable", 32'(pulses()), (i == 7) ? 32'h4 : 32'h0);
        end
        raw_btn = 6'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("bounce_release", 32'(pulses()), 32'h0);
        end

        // reset button held long enough to saturate
        raw_btn = 6'b010000;
        for (int i = 1; i <= 80; i++) begin
            tick();
            chk("sat_level", 32'(btn_reset), 32'(i >= 7));
            chk("sat_count", 32'(count_reset), (i < 7) ? 32'(0) : 32'(hold_exp(i - 7)));
        end
        raw_btn = 6'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("sat_rel_level", 32'(btn_reset), 32'(i < 7));
            chk("sat_rel_count", 32'(count_reset), (i < 7) ? 32'(5) : 32'(0));
        end

        // test button: partial second discarded on release, re-press restarts
        raw_btn = 6'b100000;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("part_level", 32'(btn_test), 32'(i >= 7));
            chk("part_count", 32'(count_test), 32'(i >= 17));
        end
        raw_btn = 6'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("part_rel_level", 32'(btn_test), 32'(i < 7));
            chk("part_rel_count", 32'(count_test), 32'(i < 7));
        end
        raw_btn = 6'b100000;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("repress_level", 32'(btn_test), 32'(i >= 7));
            chk("repress_count", 32'(count_test), 32'(i >= 17));
        end
        raw_btn = 6'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("repress_rel_level", 32'(btn_test), 32'(i < 7));
        end

        // all four need buttons on the same edge
        raw_btn = 6'b001111;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("simul_press", 32'(pulses()), (i == 7) ? 32'hF : 32'h0);
        end
        raw_btn = 6'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("simul_release", 32'(pulses()), 32'h0);
        end

        // reset asserted mid-hold with the button still down
        raw_btn = 6'b010000;
        for (int i = 1; i <= 37; i++) begin
            tick();
        end
        chk("midhold_count", 32'(count_reset), 32'(3));
        reset = 1'b1;
        tick();
        chk("midrst_pulses", 32'(pulses()), 32'(0));
        chk("midrst_levels", 32'({btn_test, btn_reset}), 32'(0));
        chk("midrst_count_reset", 32'(count_reset), 32'(0));
        chk("midrst_count_test", 32'(count_test), 32'(0));
        reset = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk("postrst_level", 32'(btn_reset), 32'(i >= 7));
            chk("postrst_count", 32'(count_reset), 32'(i >= 17));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
